// File: rtl/bp_me_pkg.sv
// Shared BedRock stream memory types: header layout, message enums, responder states, beat-count helper.
package bp_me_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

  localparam int paddr_width_p  = 40;
  localparam int did_width_p    = 4;
  localparam int lce_id_width_p = 4;
  localparam int lce_assoc_p    = 8;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [did_width_p-1:0]         did;
    logic [lce_id_width_p-1:0]      lce_id;
    logic [$clog2(lce_assoc_p)-1:0] way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_type_e    msg_type;
    logic [paddr_width_p-1:0] addr;
    bp_bedrock_msg_size_e    size;
    bp_bedrock_mem_payload_s payload;
  } bp_bedrock_mem_header_s;

  typedef enum logic [1:0] {e_ready, e_write, e_read, e_wr_resp} bp_me_stream_responder_state_e;

  function automatic int bp_me_header_width(input bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? $bits(bp_bedrock_mem_header_s) : 0;
  endfunction

  // A message smaller than one beat still occupies one beat.
  function automatic int bp_me_stream_beats(input logic [2:0] size, input int data_width);
    int bits;
    bits = 8 << size;
    return (bits <= data_width) ? 1 : bits / data_width;
  endfunction

endpackage

// File: rtl/bp_me_stream_wrap_addr.sv
// Combinational: message addr/size plus beat number k -> wrapped memory beat index and byte-enable mask.
module bp_me_stream_wrap_addr
  import bp_me_pkg::*;
#(
  parameter int mem_data_width_p = 64,
  parameter int mem_els_p = 1024,
  localparam int beat_bytes_lp = mem_data_width_p / 8,
  localparam int off_width_lp = $clog2(beat_bytes_lp),
  localparam int idx_width_lp = $clog2(mem_els_p)
) (
  input  logic [off_width_lp+idx_width_lp-1:0] addr_i,
  input  logic [2:0]                           size_i,
  input  logic [7:0]                           k_i,
  output logic [idx_width_lp-1:0]              idx_o,
  output logic [beat_bytes_lp-1:0]             mask_o
);

  logic [idx_width_lp-1:0] base;
  logic [idx_width_lp-1:0] wrap_mask;
  int n;
  int bytes;
  int off;

  always_comb begin
    n         = bp_me_stream_beats(size_i, mem_data_width_p);
    bytes     = 1 << size_i;
    off       = 32'(addr_i[off_width_lp-1:0]);
    base      = addr_i[off_width_lp +: idx_width_lp];
    wrap_mask = idx_width_lp'(n - 1);
    // Critical beat first, wrapping inside the naturally aligned block.
    idx_o     = (base & ~wrap_mask) | ((base + idx_width_lp'(k_i)) & wrap_mask);
    mask_o    = '0;
    for (int i = 0; i < beat_bytes_lp; i++) begin
      mask_o[i] = (bytes >= beat_bytes_lp) || ((i >= off) && (i < off + bytes));
    end
  end

endmodule

// File: rtl/bp_me_stream_mem_responder.sv
// Stream memory responder: one command at a time against a local beat array, critical-beat-first.
// Response v rises the cycle after the read header / last write beat; beats hold while ready_and is low.
module bp_me_stream_mem_responder
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int mem_data_width_p = 64,
  parameter int mem_els_p = 1024,
  localparam int mem_header_width_lp = bp_me_header_width(bp_params_p),
  localparam int beat_bytes_lp = mem_data_width_p / 8,
  localparam int off_width_lp = $clog2(beat_bytes_lp),
  localparam int idx_width_lp = $clog2(mem_els_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [mem_header_width_lp-1:0] mem_cmd_header_i,
  input  logic [mem_data_width_p-1:0]    mem_cmd_data_i,
  input  logic                           mem_cmd_v_i,
  output logic                           mem_cmd_ready_and_o,
  input  logic                           mem_cmd_last_i,
  output logic [mem_header_width_lp-1:0] mem_resp_header_o,
  output logic [mem_data_width_p-1:0]    mem_resp_data_o,
  output logic                           mem_resp_v_o,
  input  logic                           mem_resp_ready_and_i,
  output logic                           mem_resp_last_o
);

  bp_me_stream_responder_state_e state_r, state_n;
  bp_bedrock_mem_header_s cmd_hdr, hdr_r, wa_hdr;
  logic [7:0] k_r, wa_k;
  logic cmd_rdy, cmd_fire, resp_fire, cmd_is_wr, hdr_is_rd, last_beat, wr_en;
  logic [idx_width_lp-1:0] wa_idx;
  logic [beat_bytes_lp-1:0] wa_mask;
  logic [mem_data_width_p-1:0] mem [mem_els_p];
  logic [mem_data_width_p-1:0] rd_word, rd_rep, wr_data;
  int n_beats, wa_bytes, wa_off;

  assign cmd_hdr   = mem_cmd_header_i;
  assign cmd_rdy   = ((state_r == e_ready) || (state_r == e_write)) && !reset_i;
  assign cmd_fire  = mem_cmd_v_i && cmd_rdy;
  assign resp_fire = mem_resp_v_o && mem_resp_ready_and_i;
  assign cmd_is_wr = cmd_hdr.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};
  assign hdr_is_rd = hdr_r.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
  assign n_beats   = bp_me_stream_beats(hdr_r.size, mem_data_width_p);
  assign last_beat = (32'(k_r) == n_beats - 1);
  assign mem_cmd_ready_and_o = cmd_rdy;

  // The header beat of a write lands before the header is registered.
  assign wa_hdr   = (state_r == e_ready) ? cmd_hdr : hdr_r;
  assign wa_k     = (state_r == e_ready) ? 8'd0 : k_r;
  assign wa_bytes = 1 << wa_hdr.size;
  assign wa_off   = 32'(wa_hdr.addr[off_width_lp-1:0]);

  bp_me_stream_wrap_addr #(
    .mem_data_width_p(mem_data_width_p),
    .mem_els_p(mem_els_p)
  ) wrap (
    .addr_i(wa_hdr.addr[off_width_lp+idx_width_lp-1:0]),
    .size_i(wa_hdr.size),
    .k_i(wa_k),
    .idx_o(wa_idx),
    .mask_o(wa_mask)
  );

  assign rd_word = mem[wa_idx];

  always_comb begin
    wr_data = mem_cmd_data_i;
    rd_rep  = rd_word;
    if (wa_bytes < beat_bytes_lp) begin
      for (int i = 0; i < beat_bytes_lp; i++) begin
        wr_data[8*i +: 8] = mem_cmd_data_i[8*((i - wa_off) & (beat_bytes_lp - 1)) +: 8];
        rd_rep[8*i +: 8]  = rd_word[8*((wa_off + (i & (wa_bytes - 1))) & (beat_bytes_lp - 1)) +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < beat_bytes_lp; i++) begin
        if (wa_mask[i]) mem[wa_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      k_r   <= '0;
      hdr_r <= '0;
    end else begin
      case (state_r)
        e_ready: if (cmd_fire) begin
          hdr_r <= cmd_hdr;
          k_r   <= cmd_is_wr ? 8'd1 : 8'd0;
        end
        e_write: if (cmd_fire) k_r <= k_r + 8'd1;
        e_read:  if (resp_fire) k_r <= last_beat ? 8'd0 : k_r + 8'd1;
        default: k_r <= '0;
      endcase
    end
  end

  always_comb begin
    state_n           = state_r;
    wr_en             = 1'b0;
    mem_resp_v_o      = 1'b0;
    mem_resp_last_o   = 1'b0;
    mem_resp_header_o = '0;
    mem_resp_data_o   = '0;
    case (state_r)
      e_ready: if (cmd_fire) begin
        wr_en = cmd_is_wr;
        if (!cmd_is_wr)          state_n = e_read;
        else if (mem_cmd_last_i) state_n = e_wr_resp;
        else                     state_n = e_write;
      end
      e_write: if (cmd_fire) begin
        wr_en = 1'b1;
        if (mem_cmd_last_i) state_n = e_wr_resp;
      end
      e_wr_resp: begin
        mem_resp_v_o      = 1'b1;
        mem_resp_last_o   = 1'b1;
        mem_resp_header_o = hdr_r;
        if (mem_resp_ready_and_i) state_n = e_ready;
      end
      e_read: begin
        mem_resp_v_o      = 1'b1;
        mem_resp_last_o   = last_beat;
        mem_resp_header_o = hdr_r;
        // Unsupported message types read back as zero and never touch memory.
        mem_resp_data_o   = hdr_is_rd ? rd_rep : '0;
        if (mem_resp_ready_and_i && last_beat) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
    if (reset_i) begin
      state_n           = e_ready;
      wr_en             = 1'b0;
      mem_resp_v_o      = 1'b0;
      mem_resp_last_o   = 1'b0;
      mem_resp_header_o = '0;
      mem_resp_data_o   = '0;
    end
  end

  rd_single_beat: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_r == e_ready && cmd_fire && cmd_hdr.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd})
      |-> mem_cmd_last_i);
  wr_beat_overrun: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_r == e_write && cmd_fire) |-> (32'(k_r) < n_beats));

endmodule

// File: tb/tb_bp_me_stream_mem_responder.sv
// Directed bench for the stream memory responder; expected beats are queued at stimulus time and popped on output.
module tb_bp_me_stream_mem_responder;
  import bp_me_pkg::*;

  localparam int W  = 64;
  localparam int HW = $bits(bp_bedrock_mem_header_s);

  typedef struct packed {
    bp_bedrock_mem_header_s hdr;
    logic [W-1:0]           data;
    logic                   last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bp_bedrock_mem_header_s cmd_header;
  logic [W-1:0] cmd_data;
  logic cmd_v, cmd_last, cmd_ready;
  logic [HW-1:0] resp_header;
  logic [W-1:0] resp_data;
  logic resp_v, resp_ready, resp_last;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  bp_me_stream_mem_responder #(
    .bp_params_p(e_bp_default_cfg),
    .mem_data_width_p(W),
    .mem_els_p(1024)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .mem_cmd_header_i(cmd_header),
    .mem_cmd_data_i(cmd_data),
    .mem_cmd_v_i(cmd_v),
    .mem_cmd_ready_and_o(cmd_ready),
    .mem_cmd_last_i(cmd_last),
    .mem_resp_header_o(resp_header),
    .mem_resp_data_o(resp_data),
    .mem_resp_v_o(resp_v),
    .mem_resp_ready_and_i(resp_ready),
    .mem_resp_last_o(resp_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                    input logic [paddr_width_p-1:0] a,
                                                    input bp_bedrock_msg_size_e s);
    bp_bedrock_mem_header_s h;
    h = '0;
    h.msg_type       = t;
    h.addr           = a;
    h.size           = s;
    h.payload.did    = 4'h1;
    h.payload.lce_id = 4'h2;
    h.payload.way_id = 3'h5;
    return h;
  endfunction

  task automatic push(input bp_bedrock_mem_header_s h, input logic [W-1:0] d, input logic l);
    exp_t e;
    e.hdr  = h;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_beat(input bp_bedrock_mem_header_s h, input logic [W-1:0] d, input logic l);
    int t = 0;
    cmd_header = h;
    cmd_data   = d;
    cmd_last   = l;
    cmd_v      = 1'b1;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_v    = 1'b0;
    cmd_last = 1'b0;
  endtask

  task automatic recv(input int n, input int stall_at);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (resp_v !== 1'b1 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check("resp_v_wait", resp_v, 1'b1);
      check("sb_underflow", exp_q.size() > 0, 1'b1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      if (i == stall_at) begin
        resp_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("stall_v", resp_v, 1'b1);
          check("stall_data", resp_data, e.data);
          check("stall_last", resp_last, e.last);
          check("stall_cmd_rdy", cmd_ready, 1'b0);
        end
        resp_ready = 1'b1;
      end
      check("resp_data", resp_data, e.data);
      check("resp_last", resp_last, e.last);
      check("resp_hdr", resp_header, e.hdr);
      check("resp_cmd_rdy", cmd_ready, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bp_bedrock_mem_header_s h;
    reset      = 1'b1;
    cmd_v      = 1'b0;
    cmd_last   = 1'b0;
    cmd_data   = '0;
    cmd_header = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rdy", cmd_ready, 1'b0);
    check("rst_resp_v", resp_v, 1'b0);
    check("rst_resp_last", resp_last, 1'b0);
    check("rst_resp_hdr", resp_header, '0);
    check("rst_resp_data", resp_data, '0);
    reset = 1'b0;
    #1;
    check("cmd_rdy_after_rst", cmd_ready, 1'b1);

    // 8B write then read back
    h = mk_hdr(e_bedrock_mem_uc_wr, 'h80, e_bedrock_msg_size_8);
    push(h, '0, 1'b1);
    send_beat(h, 64'hDEADBEEF_CAFEF00D, 1'b1);
    check("wr_resp_latency", resp_v, 1'b1);
    recv(1, -1);
    h = mk_hdr(e_bedrock_mem_uc_rd, 'h80, e_bedrock_msg_size_8);
    push(h, 64'hDEADBEEF_CAFEF00D, 1'b1);
    send_beat(h, '0, 1'b1);
    check("rd_resp_latency", resp_v, 1'b1);
    recv(1, -1);

    // 64B block write, then wrapped read from beat 3 with a stall at the third beat
    h = mk_hdr(e_bedrock_mem_wr, 'h100, e_bedrock_msg_size_64);
    push(h, '0, 1'b1);
    for (int k = 0; k < 8; k++) send_beat(h, 64'(k), k == 7);
    check("blk_wr_resp_latency", resp_v, 1'b1);
    recv(1, -1);
    h = mk_hdr(e_bedrock_mem_rd, 'h118, e_bedrock_msg_size_64);
    for (int k = 0; k < 8; k++) push(h, 64'((k + 3) % 8), k == 7);
    send_beat(h, '0, 1'b1);
    recv(8, 2);

    // Sub-beat write merges one byte into an existing word
    h = mk_hdr(e_bedrock_mem_uc_wr, 'h200, e_bedrock_msg_size_8);
    push(h, '0, 1'b1);
    send_beat(h, 64'h11223344_55667788, 1'b1);
    recv(1, -1);
    h = mk_hdr(e_bedrock_mem_uc_wr, 'h203, e_bedrock_msg_size_1);
    push(h, '0, 1'b1);
    send_beat(h, 64'h00000000_000000AB, 1'b1);
    recv(1, -1);
    h = mk_hdr(e_bedrock_mem_uc_rd, 'h200, e_bedrock_msg_size_8);
    push(h, 64'h11223344_AB667788, 1'b1);
    send_beat(h, '0, 1'b1);
    recv(1, -1);
    h = mk_hdr(e_bedrock_mem_uc_rd, 'h203, e_bedrock_msg_size_1);
    push(h, 64'hABABABAB_ABABABAB, 1'b1);
    send_beat(h, '0, 1'b1);
    recv(1, -1);

    // Reset in the middle of a block read
    h = mk_hdr(e_bedrock_mem_rd, 'h100, e_bedrock_msg_size_64);
    for (int k = 0; k < 4; k++) push(h, 64'(k), 1'b0);
    send_beat(h, '0, 1'b1);
    recv(4, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_resp_v", resp_v, 1'b0);
    check("midrst_cmd_rdy", cmd_ready, 1'b1);
    for (int k = 0; k < 8; k++) push(h, 64'(k), k == 7);
    send_beat(h, '0, 1'b1);
    recv(8, -1);

    // Unsupported type: zero data, memory untouched
    h = mk_hdr(e_bedrock_mem_amo, 'h80, e_bedrock_msg_size_8);
    push(h, '0, 1'b1);
    send_beat(h, 64'h55555555_55555555, 1'b1);
    recv(1, -1);
    h = mk_hdr(e_bedrock_mem_uc_rd, 'h80, e_bedrock_msg_size_8);
    push(h, 64'hDEADBEEF_CAFEF00D, 1'b1);
    send_beat(h, '0, 1'b1);
    recv(1, -1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
